// File: rtl/cqu_mem_pkg.sv
// Shared definitions for the data-memory bridge.
//   state_e        : bridge FSM states
//   TimeoutDefault : default REQ+WAIT cycle budget before forced completion
//   MisalignRdata  : load value returned for misaligned or timed-out accesses
package cqu_mem_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StDone = 2'd3
    } state_e;

    localparam int unsigned TimeoutDefault = 255;
    localparam logic [31:0] MisalignRdata  = 32'h0000_0000;

endpackage

// File: rtl/bus_timeout_counter.sv
// Cycle counter bounding how long an access may sit in REQ+WAIT.
// Ports:
//   clk, rstn : clock, synchronous active-low reset
//   clear     : zero the count (held while the bridge is idle)
//   enable    : count this cycle (bridge in REQ or WAIT)
//   expired   : combinational, high in the TIMEOUT-th enabled cycle
module bus_timeout_counter #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TO_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Count starts at 0 in the first REQ cycle, so TIMEOUT-1 marks the last allowed cycle.
    assign expired = enable & (cnt_q == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/data_mem_bridge.sv
// Bridges the datapath's single-cycle data-memory port onto a req/gnt/rvalid bus,
// stalling the pipeline while an access is outstanding.
// Ports:
//   clk, rstn                 : clock, synchronous active-low reset
//   mem_addr/mem_wdata        : datapath address and store data
//   mem_read/mem_write        : level requests, held while mem_stall=1
//   mem_rdata                 : registered load result, valid when mem_stall drops
//   mem_stall                 : combinational hold to the pipeline
//   bus_req/bus_we/bus_addr/bus_wdata : registered bus request and payload
//   bus_gnt/bus_rvalid/bus_rdata      : bus grant and read response
//   err_misalign/err_timeout  : sticky error flags
module data_mem_bridge
    import cqu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = TimeoutDefault,
    parameter int unsigned TO_W    = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_stall,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              err_misalign,
    output logic              err_timeout
);

    state_e state_q;
    logic   req;
    logic   misaligned;
    logic   to_expired;

    assign req        = mem_read | mem_write;
    assign misaligned = req & (mem_addr[1:0] != 2'b00);

    // Misaligned accesses complete in IDLE without a bus cycle, so they never stall.
    assign mem_stall = ((state_q == StIdle) & req & ~misaligned) |
                       (state_q == StReq) | (state_q == StWait);

    bus_timeout_counter #(
        .TIMEOUT(TIMEOUT),
        .TO_W   (TO_W)
    ) u_timeout (
        .clk    (clk),
        .rstn   (rstn),
        .clear  (state_q == StIdle),
        .enable ((state_q == StReq) | (state_q == StWait)),
        .expired(to_expired)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= StIdle;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            mem_rdata    <= '0;
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (misaligned) begin
                        err_misalign <= 1'b1;
                        mem_rdata    <= DATA_W'(MisalignRdata);
                    end else if (req) begin
                        bus_addr  <= {mem_addr[ADDR_W-1:2], 2'b00};
                        bus_wdata <= mem_wdata;
                        bus_we    <= mem_write;  // write wins when both are set
                        bus_req   <= 1'b1;
                        state_q   <= StReq;
                    end
                end
                StReq: begin
                    // Grant beats a timeout landing in the same cycle.
                    if (bus_gnt) begin
                        bus_req <= 1'b0;
                        state_q <= bus_we ? StDone : StWait;
                    end else if (to_expired) begin
                        err_timeout <= 1'b1;
                        mem_rdata   <= DATA_W'(MisalignRdata);
                        bus_req     <= 1'b0;
                        state_q     <= StDone;
                    end
                end
                StWait: begin
                    if (bus_rvalid) begin
                        mem_rdata <= bus_rdata;
                        state_q   <= StDone;
                    end else if (to_expired) begin
                        err_timeout <= 1'b1;
                        mem_rdata   <= DATA_W'(MisalignRdata);
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    // Unconditional return keeps the still-held request from re-issuing here.
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
